// File: rtl/ps2_host_if.sv
// rtl/ps2_host_if.sv - LED-request and receive-side signals between the PS/2 host controller and its client.
interface ps2_host_if;
  logic       led_req;
  logic [2:0] led_bits;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output led_req, led_bits,
    input  rx_byte, rx_valid, frame_err, busy, done, err
  );

  modport slave (
    input  led_req, led_bits,
    output rx_byte, rx_valid, frame_err, busy, done, err
  );
endinterface

// File: rtl/ps2_host_ctrl.sv
// rtl/ps2_host_ctrl.sv - PS/2 keyboard host: frame receiver plus LED-set (0xED, bits) transmitter.
// Open-drain pads are built above this block; *_oe = 1 pulls the line low.
module ps2_host_ctrl #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 2
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  ps2_host_if.slave  host
);
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_TX_BITS, S_TX_ACK, S_WAIT_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    rx_cnt_q, rx_cnt_d;
  logic [9:0]    rx_sh_q, rx_sh_d;
  logic [3:0]    tx_cnt_q, tx_cnt_d;
  logic          dout_q, dout_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          byte_sel_q, byte_sel_d;
  logic [2:0]    led_q, led_d;
  logic          pending_q, pending_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic       fall, data_s, rx_active, timeout, start, frame_end, frame_good;
  logic [7:0] tx_byte, rx_data;

  assign clk_sync_d  = {clk_sync_q[1:0], ps2_clk_i};
  assign data_sync_d = {data_sync_q[0], ps2_data_i};
  assign fall        = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_s      = data_sync_q[1];
  assign tx_byte     = byte_sel_q ? {5'b0, led_q} : 8'hED;
  assign rx_data     = rx_sh_q[8:1];
  assign rx_active   = (state_q == S_IDLE) || (state_q == S_WAIT_RESP);
  assign timeout     = (tmo_q == TW'(TIMEOUT_CYC - 1)) && !fall;
  assign start       = (state_q == S_IDLE) && (host.led_req || pending_q) && (rx_cnt_q == 4'd0);
  assign frame_end   = rx_active && fall && (rx_cnt_q == 4'd10);
  // rx_sh holds {parity, d7..d0, start}; data_s is the stop bit on the final fall
  assign frame_good  = ~rx_sh_q[0] & data_s & (^rx_sh_q[9:1]);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
      inh_q       <= '0;
      tmo_q       <= '0;
      rx_cnt_q    <= '0;
      rx_sh_q     <= '0;
      tx_cnt_q    <= '0;
      dout_q      <= 1'b0;
      retry_q     <= '0;
      byte_sel_q  <= 1'b0;
      led_q       <= '0;
      pending_q   <= 1'b0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      inh_q       <= inh_d;
      tmo_q       <= tmo_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_cnt_q    <= tx_cnt_d;
      dout_q      <= dout_d;
      retry_q     <= retry_d;
      byte_sel_q  <= byte_sel_d;
      led_q       <= led_d;
      pending_q   <= pending_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    inh_d       = inh_q;
    tmo_d       = tmo_q;
    rx_cnt_d    = rx_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_cnt_d    = tx_cnt_q;
    dout_d      = dout_q;
    retry_d     = retry_q;
    byte_sel_d  = byte_sel_q;
    led_d       = led_q;
    pending_d   = pending_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (!rx_active) begin
      rx_cnt_d = 4'd0;
    end else if (fall) begin
      if (rx_cnt_q == 4'd10) begin
        rx_cnt_d = 4'd0;
      end else begin
        rx_cnt_d = rx_cnt_q + 4'd1;
        rx_sh_d  = {data_s, rx_sh_q[9:1]};
      end
    end else if (timeout) begin
      rx_cnt_d = 4'd0;
    end
    if (frame_end && !frame_good) frame_err_d = 1'b1;

    if (start)             pending_d = 1'b0;
    else if (host.led_req) pending_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (frame_end && frame_good) begin
          rx_byte_d  = rx_data;
          rx_valid_d = 1'b1;
        end
        if (start) begin
          state_d    = S_INHIBIT;
          inh_d      = '0;
          led_d      = host.led_bits;
          byte_sel_d = 1'b0;
          retry_d    = '0;
        end
      end
      S_INHIBIT: begin
        if (inh_q == IW'(INHIBIT_CYC - 1)) state_d = S_RTS;
        else                               inh_d   = inh_q + IW'(1);
      end
      S_RTS: begin
        if (fall) begin
          state_d  = S_TX_BITS;
          tx_cnt_d = 4'd1;
          dout_d   = ~tx_byte[0];
        end else if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_TX_BITS: begin
        if (fall) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q < 4'd8) begin
            dout_d = ~tx_byte[tx_cnt_q[2:0]];
          end else if (tx_cnt_q == 4'd8) begin
            dout_d = ^tx_byte;  // odd parity bit is ~^byte, driven inverted
          end else begin
            dout_d  = 1'b0;
            state_d = S_TX_ACK;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_TX_ACK: begin
        if (fall) begin
          state_d = data_s ? S_IDLE : S_WAIT_RESP;
          err_d   = data_s;
        end else if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_WAIT_RESP: begin
        if (frame_end && frame_good) begin
          if (rx_data == 8'hFA) begin
            if (!byte_sel_q) begin
              byte_sel_d = 1'b1;
              retry_d    = '0;
              inh_d      = '0;
              state_d    = S_INHIBIT;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else if (rx_data == 8'hFE) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + RW'(1);
              inh_d   = '0;
              state_d = S_INHIBIT;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            rx_byte_d  = rx_data;
            rx_valid_d = 1'b1;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // one timer serves both the RX resync and the TX abort
    if (fall || (state_d != state_q))        tmo_d = '0;
    else if (tmo_q != TW'(TIMEOUT_CYC - 1))  tmo_d = tmo_q + TW'(1);
  end

  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    unique case (state_q)
      S_INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = (inh_q == IW'(INHIBIT_CYC - 1));
      end
      S_RTS:     ps2_data_oe = 1'b1;
      S_TX_BITS: ps2_data_oe = dout_q;
      default: ;
    endcase
  end

  assign host.rx_byte   = rx_byte_q;
  assign host.rx_valid  = rx_valid_q;
  assign host.frame_err = frame_err_q;
  assign host.busy      = (state_q != S_IDLE) || pending_q;
  assign host.done      = done_q;
  assign host.err       = err_q;
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb/tb_ps2_host_ctrl.sv - scoreboard bench for ps2_host_ctrl with a behavioural PS/2 keyboard on the pads.
module tb_ps2_host_ctrl;
  localparam int INH = 20;
  localparam int TMO = 600;
  localparam int MR  = 2;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe, ps2_data_oe;
  logic line_clk, line_data;

  assign line_clk  = dev_clk & ~ps2_clk_oe;
  assign line_data = dev_data & ~ps2_data_oe;

  ps2_host_if host_if ();

  ps2_host_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .MAX_RETRY(MR)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk_i  (line_clk),
    .ps2_data_i (line_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .host       (host_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] sb[$];   // {kind, byte}: 0 rx_valid, 1 frame_err, 2 done, 3 err
  int inh_run  = 0;
  int last_inh = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic sb_pop(input logic [9:0] got, input string name);
    logic [9:0] e;
    if (sb.size() == 0) begin
      check(1'b0, {"unexpected_", name}, int'(got), 0);
    end else begin
      e = sb.pop_front();
      check(e == got, name, int'(got), int'(e));
    end
  endtask

  always @(negedge clk) begin
    if (clrn) begin
      if (host_if.rx_valid)  sb_pop({2'd0, host_if.rx_byte}, "rx_valid");
      if (host_if.frame_err) sb_pop(10'h100, "frame_err");
      if (host_if.done)      sb_pop(10'h200, "done");
      if (host_if.err)       sb_pop(10'h300, "err");
      if (host_if.done || host_if.err)
        check(!(host_if.done && host_if.err), "done_err_exclusive",
              int'({host_if.done, host_if.err}), 0);
    end
  end

  always @(negedge clk) begin
    if (ps2_clk_oe) inh_run <= inh_run + 1;
    else if (inh_run != 0) begin
      last_inh <= inh_run;
      inh_run  <= 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse_req();
    @(negedge clk) host_if.led_req = 1'b1;
    @(negedge clk) host_if.led_req = 1'b0;
  endtask

  task automatic dev_send(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      dev_data = f[i];
      wait_cycles(4);
      dev_clk = 1'b0;
      wait_cycles(8);
      dev_clk = 1'b1;
      wait_cycles(4);
    end
    dev_data = 1'b1;
  endtask

  task automatic respond(input logic [7:0] b);
    wait_cycles(20);
    dev_send(b, 1'b0);
  endtask

  task automatic wait_rts(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_data_oe) begin
        ok = 1'b1;
        break;
      end
    end
    check(ok, "rts_seen", int'(ok), 1);
  endtask

  task automatic dev_recv(input logic [7:0] exp);
    bit ok;
    logic [9:0] bits;
    wait_rts(ok);
    if (ok) begin
      @(negedge clk);
      check(last_inh >= INH, "inhibit_len", last_inh, INH);
      wait_cycles(8);
      for (int i = 0; i < 10; i++) begin
        dev_clk = 1'b0;
        wait_cycles(8);
        dev_clk = 1'b1;
        bits[i] = line_data;
        wait_cycles(8);
      end
      check(bits == {1'b1, ~^exp, exp}, "tx_frame", int'(bits), int'({1'b1, ~^exp, exp}));
      dev_data = 1'b0;
      wait_cycles(4);
      dev_clk = 1'b0;
      wait_cycles(8);
      dev_clk = 1'b1;
      dev_data = 1'b1;
      wait_cycles(8);
    end
  endtask

  initial begin
    bit ok;
    bit got;
    int k;
    host_if.led_req  = 1'b0;
    host_if.led_bits = 3'b000;
    wait_cycles(5);
    @(negedge clk);
    check({ps2_clk_oe, ps2_data_oe, host_if.busy, host_if.done, host_if.err,
           host_if.rx_valid, host_if.frame_err, host_if.rx_byte} == 15'd0, "reset_outputs",
          int'({ps2_clk_oe, ps2_data_oe, host_if.busy, host_if.done, host_if.err,
                host_if.rx_valid, host_if.frame_err, host_if.rx_byte}), 0);
    clrn = 1'b1;
    wait_cycles(10);

    // good and bad-parity receive frames
    sb.push_back({2'd0, 8'h1C});
    dev_send(8'h1C, 1'b0);
    wait_cycles(20);
    sb.push_back(10'h100);
    dev_send(8'h1C, 1'b1);
    wait_cycles(20);
    check(host_if.rx_byte == 8'h1C, "rx_byte_kept", int'(host_if.rx_byte), 8'h1C);

    // plain LED sequence
    host_if.led_bits = 3'b100;
    sb.push_back(10'h200);
    pulse_req();
    check(host_if.busy == 1'b1, "busy_during_seq", int'(host_if.busy), 1);
    dev_recv(8'hED); respond(8'hFA);
    dev_recv(8'h04); respond(8'hFA);
    wait_cycles(30);
    check(host_if.busy == 1'b0, "busy_after_done", int'(host_if.busy), 0);

    // one resend, then success
    sb.push_back(10'h200);
    pulse_req();
    dev_recv(8'hED); respond(8'hFE);
    dev_recv(8'hED); respond(8'hFA);
    dev_recv(8'h04); respond(8'hFA);
    wait_cycles(30);
    check(host_if.busy == 1'b0, "busy_after_resend", int'(host_if.busy), 0);

    // retries exhausted
    sb.push_back(10'h300);
    pulse_req();
    for (int r = 0; r <= MR; r++) begin
      dev_recv(8'hED);
      respond(8'hFE);
    end
    wait_cycles(30);
    check(host_if.busy == 1'b0, "busy_after_retry_err", int'(host_if.busy), 0);

    // silent device, plus a queued second request
    host_if.led_bits = 3'b011;
    sb.push_back(10'h300);
    sb.push_back(10'h200);
    pulse_req();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ps2_clk_oe) break;
    end
    pulse_req();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!ps2_clk_oe) break;
    end
    k = 0;
    got = 1'b0;
    for (int n = 0; n < TMO + 50; n++) begin
      @(negedge clk);
      k++;
      if (host_if.err) begin
        got = 1'b1;
        check({ps2_clk_oe, ps2_data_oe} == 2'b00, "oe_released_at_err",
              int'({ps2_clk_oe, ps2_data_oe}), 0);
        break;
      end
    end
    check(got && (k == TMO), "timeout_latency", k, TMO);
    dev_recv(8'hED); respond(8'hFA);
    dev_recv(8'h03); respond(8'hFA);
    wait_cycles(30);
    check(host_if.busy == 1'b0, "busy_after_pending", int'(host_if.busy), 0);

    // reset in the middle of transmitting 0xED
    pulse_req();
    wait_rts(ok);
    wait_cycles(8);
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0;
      wait_cycles(8);
      dev_clk = 1'b1;
      wait_cycles(8);
    end
    dev_clk = 1'b0;
    wait_cycles(6);
    @(negedge clk);
    check(ps2_data_oe == 1'b0, "tx_bit3_of_ED", int'(ps2_data_oe), 0);
    clrn = 1'b0;
    #1;
    check({ps2_clk_oe, ps2_data_oe, host_if.busy} == 3'b000, "async_reset_mid_tx",
          int'({ps2_clk_oe, ps2_data_oe, host_if.busy}), 0);
    dev_clk = 1'b1;
    wait_cycles(5);
    @(negedge clk) clrn = 1'b1;
    wait_cycles(10);
    sb.push_back({2'd0, 8'h1C});
    dev_send(8'h1C, 1'b0);
    wait_cycles(50);
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
